// File: rtl/servant_trace_pkg.sv
// Shared constants for the servant PC trace block: record tags, field offsets, record width.
package servant_trace_pkg;

  localparam logic [1:0] TAG_PC  = 2'b00;
  localparam logic [1:0] TAG_IRQ = 2'b01;
  localparam logic [1:0] TAG_OVF = 2'b10;

  // Record layout, LSB first: payload[31:0], delta[DELTA_W-1:0], tag[1:0]
  localparam int PAYLOAD_LSB = 0;
  localparam int DELTA_LSB   = 32;

  function automatic int rec_w(input int delta_w);
    return 2 + delta_w + 32;
  endfunction

  function automatic int tag_lsb(input int delta_w);
    return DELTA_LSB + delta_w;
  endfunction

endpackage

// File: rtl/servant_pc_trace_if.sv
// Trace tap (pc/irq from the core) and the record drain stream of servant_pc_trace.
interface servant_pc_trace_if #(parameter int DELTA_W = 14);
  import servant_trace_pkg::*;

  logic [31:0]               pc_adr;
  logic                      pc_vld;
  logic                      timer_irq;
  logic [rec_w(DELTA_W)-1:0] tr_data;
  logic                      tr_vld;
  logic                      tr_rdy;

  modport master (output pc_adr, pc_vld, timer_irq, tr_rdy, input tr_data, tr_vld);
  modport slave  (input pc_adr, pc_vld, timer_irq, tr_rdy, output tr_data, tr_vld);
endinterface

// File: rtl/servant_trace_fifo.sv
// Synchronous FIFO for trace records; extra pointer MSB tells full from empty.
module servant_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  output logic                     full,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;
  // Head reads as zero when empty so the stream output is clean after reset.
  assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk)
    if (push && !full) mem[wptr[AW-1:0]] <= din;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end

endmodule

// File: rtl/servant_pc_trace.sv
// Timestamped fetch trace with overflow accounting and halt detection.
// Optional IRQ markers are built when SERVANT_TRACE_IRQ_EN is defined.
module servant_pc_trace
  import servant_trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int DELTA_W     = 14,
  parameter int HALT_REPEAT = 8
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst_n,
  input  logic                   en,
  servant_pc_trace_if.slave      tap,
  output logic [$clog2(DEPTH):0] level,
  output logic                   halted
);
  localparam int REC_W   = rec_w(DELTA_W);
  localparam int TAG_LSB = tag_lsb(DELTA_W);
  localparam int RW      = $clog2(HALT_REPEAT) + 1;
  localparam logic [DELTA_W-1:0] DMAX = '1;
  localparam logic [RW-1:0]      RMAX = RW'(HALT_REPEAT - 1);

  logic               full, empty, push, ovf, pc_ev, any_ev;
  logic [REC_W-1:0]   din, dout;
  logic [DELTA_W-1:0] dcnt, delta;
  logic [31:0]        drop_cnt, drop_nxt, payload;
  logic [32:0]        drop_sum;
  logic [1:0]         tag, ndrop;

  assign pc_ev = en & tap.pc_vld;
  assign delta = (dcnt == DMAX) ? DMAX : dcnt + 1'b1;

`ifdef SERVANT_TRACE_IRQ_EN
  logic        irq_q, irq_ev, hold_vld, hold_set, hold_clr;
  logic [31:0] hold_adr;

  assign irq_ev = en & tap.timer_irq & ~irq_q;
  assign any_ev = pc_ev | irq_ev;

  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      irq_q    <= 1'b0;
      hold_vld <= 1'b0;
      hold_adr <= '0;
    end else begin
      irq_q <= tap.timer_irq;
      if (hold_set) begin
        hold_vld <= 1'b1;
        hold_adr <= tap.pc_adr;
      end else if (hold_clr) begin
        hold_vld <= 1'b0;
      end
    end
`else
  logic unused_irq;
  assign unused_irq = tap.timer_irq;
  assign any_ev     = pc_ev;
`endif

  // Arbiter: pending overflow record first; events arriving alongside it are lost.
  always_comb begin
    push    = 1'b0;
    ovf     = 1'b0;
    tag     = TAG_PC;
    payload = tap.pc_adr;
    ndrop   = 2'd0;
`ifdef SERVANT_TRACE_IRQ_EN
    hold_set = 1'b0;
    hold_clr = 1'b0;
`endif
    if (drop_cnt != '0 && !full) begin
      push    = 1'b1;
      ovf     = 1'b1;
      tag     = TAG_OVF;
      payload = drop_cnt;
`ifdef SERVANT_TRACE_IRQ_EN
    end else if (hold_vld) begin
      ndrop = {1'b0, pc_ev} + {1'b0, irq_ev};
      if (!full) begin
        push     = 1'b1;
        payload  = hold_adr;
        hold_clr = 1'b1;
      end
    end else if (irq_ev) begin
      if (full) begin
        ndrop = {1'b0, pc_ev} + 2'd1;
      end else begin
        push     = 1'b1;
        tag      = TAG_IRQ;
        payload  = '0;
        hold_set = pc_ev;
      end
`endif
    end else if (pc_ev) begin
      if (full) ndrop = 2'd1;
      else      push  = 1'b1;
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 33'(ndrop);
  assign drop_nxt = ovf ? 32'(any_ev) : (drop_sum[32] ? '1 : drop_sum[31:0]);

  always_comb begin
    din = '0;
    din[PAYLOAD_LSB +: 32]   = payload;
    din[DELTA_LSB +: DELTA_W] = delta;
    din[TAG_LSB +: 2]        = tag;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      dcnt     <= '0;
      drop_cnt <= '0;
    end else begin
      dcnt     <= push ? '0 : delta;
      drop_cnt <= drop_nxt;
    end

  // Halt detection looks at every fetch, independent of capture enable.
  logic [31:0]   last_adr;
  logic          last_vld;
  logic [RW-1:0] rpt;

  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      last_adr <= '0;
      last_vld <= 1'b0;
      rpt      <= '0;
      halted   <= 1'b0;
    end else if (tap.pc_vld) begin
      if (last_vld && tap.pc_adr == last_adr) begin
        if (rpt != RMAX)         rpt    <= rpt + 1'b1;
        if (rpt >= RMAX - 1'b1)  halted <= 1'b1;
      end else begin
        last_adr <= tap.pc_adr;
        last_vld <= 1'b1;
        rpt      <= '0;
        halted   <= 1'b0;
      end
    end

  servant_trace_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk   (wb_clk),
    .rst_n (wb_rst_n),
    .push  (push),
    .din   (din),
    .full  (full),
    .pop   (tap.tr_rdy),
    .dout  (dout),
    .empty (empty),
    .level (level)
  );

  assign tap.tr_data = dout;
  assign tap.tr_vld  = ~empty;

endmodule
